// File: rtl/bus_arbiter_nm.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bus_arbiter_nm
//   Arbiter for N masters sharing one serial bus in front of S slaves.
//   Supports round-robin or fixed priority, latches single-cycle requests,
//   parks masters whose slave issued a split (resumed masters win the next
//   arbitration), and force-releases an owner that holds the bus too long.
//
// Ports
//   clk            bus clock, rising edge
//   rstn           synchronous active-low reset
//   m_req          per-master request (pulse or level)
//   m_done         per-master end-of-transaction pulse (owner only counts)
//   slave_sel      index of the slave currently addressed
//   s_split        split request from the addressed slave
//   s_resume       per-slave resume pulse
//   m_grant        one-hot bus grant
//   bus_owner      index of the granted master
//   bus_busy       bus currently owned
//   parked         masters waiting on a split slave
//   timeout_err    one-cycle pulse on forced release
//   arbiter_state  state code for debug
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE (0) | no owner; grant the winner among eligible masters
// OWN  (1) | grant held; wait for done, split or timeout
// RELEASE(2)| one dead cycle with the grant removed, rotate rr pointer
// -----------------------------------------------------------------------------
module bus_arbiter_nm #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 255,
    parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int SW          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic [NUM_MASTERS-1:0] m_done,
    input  logic [SW-1:0]          slave_sel,
    input  logic                   s_split,
    input  logic [NUM_SLAVES-1:0]  s_resume,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [MW-1:0]          bus_owner,
    output logic                   bus_busy,
    output logic [NUM_MASTERS-1:0] parked,
    output logic                   timeout_err,
    output logic [3:0]             arbiter_state
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [NUM_MASTERS-1:0]  pending, pending_nxt;
    logic [NUM_MASTERS-1:0]  resumed, resumed_nxt;
    logic [NUM_MASTERS-1:0]  parked_nxt;
    logic [NUM_MASTERS-1:0]  grant_nxt;
    logic [SW-1:0]           park_slave     [NUM_MASTERS];
    logic [SW-1:0]           park_slave_nxt [NUM_MASTERS];
    logic [MW-1:0]           owner_nxt;
    logic [MW-1:0]           rr_ptr, rr_ptr_nxt;
    logic [TW-1:0]           timer, timer_nxt, timer_inc;
    logic                    timeout_nxt;

    logic [NUM_MASTERS-1:0]  eligible;
    logic [NUM_MASTERS-1:0]  resumed_elig;
    logic [NUM_MASTERS-1:0]  resume_hit;
    logic                    win_valid;
    logic [MW-1:0]           win_idx;
    logic                    rr_found;
    int                      cand;

    assign timer_inc     = timer + 1'b1;
    assign bus_busy      = (state == ST_OWN);
    assign arbiter_state = {2'b00, state};

    // A resume only reaches masters already recorded as parked, so a split
    // and a resume from the same slave in one cycle never cancel out.
    always_comb begin
        resume_hit = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (parked[m] && s_resume[k] && (park_slave[m] == SW'(k))) begin
                    resume_hit[m] = 1'b1;
                end
            end
        end
    end

    assign eligible     = (pending | m_req | resumed) & ~parked;
    assign resumed_elig = resumed & ~parked;

    // Winner selection: resumed masters first (lowest index), then either a
    // rotating search starting just after the last owner or lowest index.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        rr_found  = 1'b0;
        cand      = 0;
        if (|resumed_elig) begin
            win_valid = 1'b1;
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (resumed_elig[i]) begin
                    win_idx = MW'(i);
                end
            end
        end else if (|eligible) begin
            win_valid = 1'b1;
            if (RR_MODE != 0) begin
                for (int d = 1; d <= NUM_MASTERS; d++) begin
                    cand = (int'(rr_ptr) + d) % NUM_MASTERS;
                    if (!rr_found && eligible[cand]) begin
                        win_idx  = MW'(cand);
                        rr_found = 1'b1;
                    end
                end
            end else begin
                for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                    if (eligible[i]) begin
                        win_idx = MW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending | m_req;
        resumed_nxt    = resumed | resume_hit;
        parked_nxt     = parked & ~resume_hit;
        park_slave_nxt = park_slave;
        grant_nxt      = m_grant;
        owner_nxt      = bus_owner;
        rr_ptr_nxt     = rr_ptr;
        timer_nxt      = timer;
        timeout_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nxt            = ST_OWN;
                    grant_nxt            = '0;
                    grant_nxt[win_idx]   = 1'b1;
                    owner_nxt            = win_idx;
                    pending_nxt[win_idx] = 1'b0;
                    resumed_nxt[win_idx] = 1'b0;
                    timer_nxt            = '0;
                end
            end

            ST_OWN: begin
                timer_nxt = timer_inc;
                if (m_done[bus_owner]) begin
                    state_nxt = ST_RELEASE;
                    grant_nxt = '0;
                end else if (s_split) begin
                    state_nxt                 = ST_RELEASE;
                    grant_nxt                 = '0;
                    parked_nxt[bus_owner]     = 1'b1;
                    park_slave_nxt[bus_owner] = slave_sel;
                end else if ((TIMEOUT != 0) && (timer_inc == TIMEOUT_V)) begin
                    state_nxt   = ST_RELEASE;
                    grant_nxt   = '0;
                    timeout_nxt = 1'b1;
                end
            end

            ST_RELEASE: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                if (RR_MODE != 0) begin
                    rr_ptr_nxt = bus_owner;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            m_grant     <= '0;
            bus_owner   <= '0;
            parked      <= '0;
            resumed     <= '0;
            pending     <= '0;
            rr_ptr      <= MW'(NUM_MASTERS - 1);
            timer       <= '0;
            timeout_err <= 1'b0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                park_slave[m] <= '0;
            end
        end else begin
            state       <= state_nxt;
            m_grant     <= grant_nxt;
            bus_owner   <= owner_nxt;
            parked      <= parked_nxt;
            resumed     <= resumed_nxt;
            pending     <= pending_nxt;
            rr_ptr      <= rr_ptr_nxt;
            timer       <= timer_nxt;
            timeout_err <= timeout_nxt;
            park_slave  <= park_slave_nxt;
        end
    end

endmodule
